// File: rtl/serial_parity_framer_if.sv
// Serial bit stream in, parity/frame status out, for serial_parity_framer.
interface serial_parity_framer_if;
  logic in_valid;
  logic x;
  logic sof;
  logic odd_mode;
  logic z;
  logic busy;
  logic par_valid;
  logic par_bit;
  logic frame_done;
  logic chk_err;
  logic abort;

  modport master (
    output in_valid, x, sof, odd_mode,
    input  z, busy, par_valid, par_bit, frame_done, chk_err, abort
  );

  modport slave (
    input  in_valid, x, sof, odd_mode,
    output z, busy, par_valid, par_bit, frame_done, chk_err, abort
  );
endinterface

// File: rtl/serial_parity_framer.sv
// Framed serial parity generator/checker: DATA_BITS data bits then one parity bit.
// Optional saturating error counter output err_cnt when PARITY_ERR_CNT_EN is defined.
module serial_parity_framer #(
  parameter int DATA_BITS = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  serial_parity_framer_if.slave bus
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_BITS);

  if (DATA_BITS < 1 || DATA_BITS > 64 || ERR_CNT_W < 1) begin : g_bad_cfg
    $error("serial_parity_framer: illegal DATA_BITS/ERR_CNT_W");
  end

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             z_q, z_d;
  logic             pb_q, pb_d;
  logic             pv_q, pv_d;
  logic             fd_q, fd_d;
  logic             ce_q, ce_d;
  logic             ab_q, ab_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      z_q     <= 1'b0;
      pb_q    <= 1'b0;
      pv_q    <= 1'b0;
      fd_q    <= 1'b0;
      ce_q    <= 1'b0;
      ab_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      pb_q    <= pb_d;
      pv_q    <= pv_d;
      fd_q    <= fd_d;
      ce_q    <= ce_d;
      ab_q    <= ab_d;
    end
  end

  // z carries the mode from frame start, so it already equals the expected parity at the end.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    pb_d    = pb_q;
    pv_d    = 1'b0;
    fd_d    = 1'b0;
    ce_d    = 1'b0;
    ab_d    = 1'b0;
    cnt_inc = cnt_q + CNT_W'(1);
    if (bus.in_valid) begin
      if (bus.sof) begin
        // A sof anywhere inside a frame (including the parity slot) drops that frame unchecked.
        ab_d  = (state_q != IDLE);
        z_d   = bus.x ^ bus.odd_mode;
        cnt_d = CNT_W'(1);
        if (DATA_BITS == 1) begin
          state_d = PARITY;
          pv_d    = 1'b1;
          pb_d    = bus.x ^ bus.odd_mode;
        end else begin
          state_d = DATA;
        end
      end else begin
        case (state_q)
          DATA: begin
            z_d   = z_q ^ bus.x;
            cnt_d = cnt_inc;
            if (cnt_inc == LAST) begin
              state_d = PARITY;
              pv_d    = 1'b1;
              pb_d    = z_q ^ bus.x;
            end
          end
          PARITY: begin
            fd_d    = 1'b1;
            ce_d    = (bus.x != pb_q);
            state_d = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.z          = z_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.par_valid  = pv_q;
  assign bus.par_bit    = pb_q;
  assign bus.frame_done = fd_q;
  assign bus.chk_err    = ce_q;
  assign bus.abort      = ab_q;

`ifdef PARITY_ERR_CNT_EN
  // Counts on the same edge that raises chk_err; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     err_cnt <= '0;
    else if (ce_d && err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
  end
`endif

endmodule
